// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package subtractor_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor, purely combinational: Diff = A - B - Bin, Bout set on underflow.
module full_subtractor (
   input  logic A,
   input  logic B,
   input  logic Bin,
   output logic Diff,
   output logic Bout
);

   assign Diff = A ^ B ^ Bin;
   assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial A - B - Bin, one bit per clock LSB-first; result valid WIDTH edges after start.
// No backpressure: start is ignored while busy, and a start in DONE chains back-to-back.
module serial_ripple_subtractor
   import subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             bit_diff;
   logic             bit_bout;

   full_subtractor u_fs (
      .A    (a_q[0]),
      .B    (b_q[0]),
      .Bin  (br_q),
      .Diff (bit_diff),
      .Bout (bit_bout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = bit_bout;
            res_d = {bit_diff, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            // Published outputs only move on the final bit, so they hold across later operations.
            if (cnt_q == LAST) begin
               diff_d  = {bit_diff, res_q[WIDTH-1:1]};
               bout_d  = bit_bout;
               state_d = DONE;
            end
         end
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Diff = diff_q;
   assign Bout = bout_q;

endmodule
